// File: rtl/count_sched.sv
// rtl/count_sched.sv - round-robin scheduler sharing one counter; watchdog enabled by COUNT_SCHED_TIMEOUT_EN
module count_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   len,
  input  logic [CW-1:0]        cnt_q,
  output logic                 cnt_en,
  output logic                 cnt_rst,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    COUNT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   win;
  logic [CW-1:0]   tgt_q, tgt_d;
  logic [CW-1:0]   len_win;
  logic            owner_req;
  logic            clr_fsm;

`ifdef COUNT_SCHED_TIMEOUT_EN
  // Last watchdog value before it would reach 2^CW+2, i.e. the 2^CW+2'th COUNT cycle.
  localparam logic [CW+1:0] WD_LAST = (CW+2)'((1 << CW) + 1);
  logic [CW+1:0] wd_q, wd_d;
`endif

  // First requester at or after p+1, wrapping; walking downward lets the nearest one win.
  function automatic logic [IW-1:0] pick_next(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic [IW-1:0] ix;
    w = p;
    for (int k = NREQ; k >= 1; k--) begin
      ix = IW'((int'(p) + k) % NREQ);
      if (r[ix]) w = ix;
    end
    return w;
  endfunction

  assign win       = pick_next(req, rr_q);
  assign owner_req = |(req & gnt_q);
  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  // Counter is held clear for the whole reset as well as the CLEAR state.
  assign cnt_rst   = rst | clr_fsm;

  // Select the target length of the arbitration winner.
  always_comb begin
    len_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) len_win = len[i*CW +: CW];
    end
  end

  // State, grant, round-robin pointer and latched target registers.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= IW'(NREQ - 1);
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef COUNT_SCHED_TIMEOUT_EN
  // Watchdog counting cycles spent in COUNT.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  // Next-state and output decode; abandon beats completion, completion beats timeout.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    tgt_d   = tgt_q;
    cnt_en  = 1'b0;
    clr_fsm = 1'b0;
    done    = '0;
    err     = 1'b0;
`ifdef COUNT_SCHED_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = NREQ'(1) << win;
          tgt_d   = len_win;
          rr_d    = win;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_fsm = 1'b1;
`ifdef COUNT_SCHED_TIMEOUT_EN
        wd_d    = '0;
`endif
        if (!owner_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        cnt_en = (cnt_q != tgt_q);
`ifdef COUNT_SCHED_TIMEOUT_EN
        wd_d   = wd_q + 1'b1;
`endif
        if (!owner_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == tgt_q) begin
          state_d = FINISH;
`ifdef COUNT_SCHED_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          err     = 1'b1;
          cnt_en  = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
`endif
        end
      end
      FINISH: begin
        done    = gnt_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_count_sched.sv
// tb/tb_count_sched.sv - scoreboard bench for count_sched with a behavioural shared counter
module tb_count_sched;

  localparam int K_GNT  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         kind;
    logic [3:0] who;
    int         delta;
    int         cntv;
    int         en;
  } exp_t;

  logic        ck;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  cnt_q;
  logic        cnt_en;
  logic        cnt_rst;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        err;
  logic        stuck;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  int         cyc       = 0;
  int         gnt_cyc   = 0;
  int         last_done = 0;
  int         en_cnt    = 0;
  logic [3:0] prev_gnt  = '0;
  exp_t       e;

  count_sched #(.NREQ(4), .CW(4)) dut (
    .ck      (ck),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .cnt_q   (cnt_q),
    .cnt_en  (cnt_en),
    .cnt_rst (cnt_rst),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // shared counter; stuck freezes it
  always @(posedge ck) begin
    if (cnt_rst) cnt_q <= 4'd0;
    else if (cnt_en && !stuck) cnt_q <= cnt_q + 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] who, input int delta, input int cntv, input int en);
    exp_t x;
    x.kind = kind; x.who = who; x.delta = delta; x.cntv = cntv; x.en = en;
    sb.push_back(x);
  endtask

  task automatic set_len(input int i, input logic [3:0] v);
    len[i*4 +: 4] = v;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge ck);
      n++;
    end while (done == 4'd0 && n < bound);
    chk("done_seen", int'(done != 4'd0), 1);
  endtask

  task automatic wait_count(input logic [3:0] v, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge ck);
      n++;
    end while (!(cnt_en && cnt_q == v) && n < bound);
    chk("count_reached", int'(cnt_en && cnt_q == v), 1);
  endtask

  // monitor: pops the scoreboard on every grant, done and err event
  initial begin
    forever begin
      @(negedge ck);
      cyc++;
      if (rst) begin
        prev_gnt = '0;
        en_cnt   = 0;
      end else begin
        chk("gnt_onehot0", int'($onehot0(gnt)), 1);
        if (gnt != 4'd0 && prev_gnt == 4'd0) begin
          if (sb.size() == 0) chk("unexpected_grant", int'(gnt), 0);
          else begin
            e = sb.pop_front();
            chk("gnt_kind", K_GNT, e.kind);
            chk("gnt_who", int'(gnt), int'(e.who));
            if (e.delta >= 0) chk("gnt_gap", cyc - last_done, e.delta);
          end
          gnt_cyc = cyc;
          en_cnt  = 0;
        end
        if (cnt_en) en_cnt++;
        if (done != 4'd0) begin
          if (sb.size() == 0) chk("unexpected_done", int'(done), 0);
          else begin
            e = sb.pop_front();
            chk("done_kind", K_DONE, e.kind);
            chk("done_who", int'(done), int'(e.who));
            chk("done_latency", cyc - gnt_cyc, e.delta);
            chk("done_cnt_q", int'(cnt_q), e.cntv);
            chk("done_en_cycles", en_cnt, e.en);
          end
          last_done = cyc;
        end
        if (err) begin
          if (sb.size() == 0) chk("unexpected_err", 1, 0);
          else begin
            e = sb.pop_front();
            chk("err_kind", K_ERR, e.kind);
            chk("err_who", int'(gnt), int'(e.who));
            chk("err_latency", cyc - gnt_cyc, e.delta);
          end
        end
        prev_gnt = gnt;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; req = '0; len = '0; stuck = 1'b0;
    @(negedge ck);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cnt_rst", int'(cnt_rst), 1);
    @(negedge ck);
    rst = 1'b0;
    @(negedge ck);

    // single run, requester 1, length 5
    set_len(1, 4'd5);
    push(K_GNT, 4'b0010, -1, 0, 0);
    push(K_DONE, 4'b0010, 7, 5, 5);
    req = 4'b0010;
    wait_done(30);
    req = 4'b0000;
    @(negedge ck);
    chk("single_idle_busy", int'(busy), 0);
    chk("single_hold_cnt_q", int'(cnt_q), 5);

    // zero length, requester 2
    set_len(2, 4'd0);
    push(K_GNT, 4'b0100, -1, 0, 0);
    push(K_DONE, 4'b0100, 2, 0, 0);
    req = 4'b0100;
    wait_done(30);
    req = 4'b0000;
    @(negedge ck);

    // reset in the middle of a length-9 run
    set_len(1, 4'd9);
    push(K_GNT, 4'b0010, -1, 0, 0);
    req = 4'b0010;
    wait_count(4'd3, 30);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_cnt_en", int'(cnt_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cnt_rst", int'(cnt_rst), 1);
    chk("midrst_done", int'(done), 0);
    req = 4'b1111;
    len = {4'd2, 4'd2, 4'd2, 4'd2};
    push(K_GNT, 4'b0001, -1, 0, 0); push(K_DONE, 4'b0001, 4, 2, 2);
    push(K_GNT, 4'b0010,  2, 0, 0); push(K_DONE, 4'b0010, 4, 2, 2);
    push(K_GNT, 4'b0100,  2, 0, 0); push(K_DONE, 4'b0100, 4, 2, 2);
    push(K_GNT, 4'b1000,  2, 0, 0); push(K_DONE, 4'b1000, 4, 2, 2);
    push(K_GNT, 4'b0001,  2, 0, 0); push(K_DONE, 4'b0001, 4, 2, 2);
    @(negedge ck);
    chk("midrst_cnt_rst_held", int'(cnt_rst), 1);
    chk("midrst_cnt_q_cleared", int'(cnt_q), 0);
    rst = 1'b0;

    // round robin with all requesters held
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge ck);
      if (done != 4'd0) n++;
    end
    req = 4'b0000;
    chk("rr_done_count", n, 5);
    @(negedge ck);

    // abandon requester 3 after 4 counts, requester 0 waiting with length 15
    set_len(3, 4'd15);
    set_len(0, 4'd15);
    push(K_GNT, 4'b1000, -1, 0, 0);
    req = 4'b1000;
    wait_count(4'd4, 30);
    push(K_GNT, 4'b0001, -1, 0, 0);
    push(K_DONE, 4'b0001, 17, 15, 15);
    req = 4'b0001;
    @(negedge ck);
    chk("abandon_cnt_en", int'(cnt_en), 0);
    chk("abandon_busy", int'(busy), 0);
    chk("abandon_gnt", int'(gnt), 0);
    chk("abandon_done", int'(done), 0);
    wait_done(40);
    req = 4'b0000;
    @(negedge ck);

    // stuck counter, length 7
    stuck = 1'b1;
    set_len(2, 4'd7);
    push(K_GNT, 4'b0100, -1, 0, 0);
`ifdef COUNT_SCHED_TIMEOUT_EN
    push(K_ERR, 4'b0100, 18, 0, 0);
    req = 4'b0100;
    n = 0;
    do begin
      @(negedge ck);
      n++;
    end while (!err && n < 40);
    chk("timeout_err_seen", int'(err), 1);
    req = 4'b0000;
    @(negedge ck);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_err_pulse", int'(err), 0);
`else
    req = 4'b0100;
    repeat (40) @(negedge ck);
    chk("stuck_busy", int'(busy), 1);
    chk("stuck_err", int'(err), 0);
    chk("stuck_cnt_en", int'(cnt_en), 1);
    req = 4'b0000;
    @(negedge ck);
    chk("stuck_abandon_busy", int'(busy), 0);
`endif
    stuck = 1'b0;
    repeat (2) @(negedge ck);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
